// File: rtl/pwm_gen_multi.sv
// Multi-channel PWM generator with a shared prescaled timebase.
// Edge/center alignment; all config double-buffered, committed at period start.
module pwm_gen_multi #(
   parameter int WIDTH      = 8,
   parameter int NUM_CH     = 4,
   parameter int PRESCALE_W = 8
) (
   input  logic                    i_clk,
   input  logic                    i_rst_n,
   input  logic                    i_en,
   input  logic                    i_center,
   input  logic [WIDTH-1:0]        i_period,
   input  logic [PRESCALE_W-1:0]   i_prescale,
   input  logic [NUM_CH*WIDTH-1:0] i_duty,
   input  logic                    i_load,
   output logic                    o_load_ack,
   output logic [NUM_CH-1:0]       o_pwm_out,
   output logic                    o_e,
   output logic [WIDTH-1:0]        o_cnt
);

   logic [NUM_CH*WIDTH-1:0] r_pend_duty, r_act_duty;
   logic [WIDTH-1:0]        r_pend_top, r_act_top;
   logic [PRESCALE_W-1:0]   r_pend_psc, r_act_psc;
   logic                    r_pend_ctr, r_act_ctr;
   logic                    r_pend;
   logic [PRESCALE_W-1:0]   r_psc;
   logic [WIDTH-1:0]        r_cnt;
   logic                    r_dn;
   logic                    r_en_q;
   logic                    r_e;
   logic                    r_ack;
   logic [NUM_CH-1:0]       r_pwm;

   logic                    w_tick;
   logic                    w_rise;
   logic                    w_start;
   logic                    w_commit;
   logic [WIDTH-1:0]        w_cnt_nxt;
   logic                    w_dn_nxt;
   logic [NUM_CH-1:0]       w_pwm;

   assign w_tick   = i_en & (r_psc == r_act_psc);
   assign w_rise   = i_en & ~r_en_q;
   assign w_commit = r_pend & (~i_en | w_start);

   // Timebase next count/direction and period-start detection
   always_comb begin
      w_cnt_nxt = r_cnt;
      w_dn_nxt  = r_dn;
      w_start   = 1'b0;
      if (w_rise) begin
         w_cnt_nxt = '0;
         w_dn_nxt  = 1'b0;
         w_start   = 1'b1;
      end else if (w_tick) begin
         if (!r_act_ctr) begin
            if (r_cnt == r_act_top) begin
               w_cnt_nxt = '0;
               w_start   = 1'b1;
            end else begin
               w_cnt_nxt = r_cnt + WIDTH'(1);
            end
         end else if (r_act_top == '0) begin
            w_cnt_nxt = '0;
            w_start   = 1'b1;
         end else if (r_dn) begin
            if (r_cnt <= WIDTH'(1)) begin
               w_cnt_nxt = '0;
               w_dn_nxt  = 1'b0;
               w_start   = 1'b1;
            end else begin
               w_cnt_nxt = r_cnt - WIDTH'(1);
            end
         end else begin
            w_cnt_nxt = r_cnt + WIDTH'(1);
            if (r_cnt + WIDTH'(1) >= r_act_top) begin
               w_dn_nxt = 1'b1;
            end
         end
      end
   end

   // Per-channel compare against pre-edge count
   always_comb begin
      w_pwm = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         w_pwm[i] = i_en & (r_cnt < r_act_duty[i*WIDTH +: WIDTH]);
      end
   end

   // Shadow capture and commit of configuration
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_pend      <= 1'b0;
         r_pend_duty <= '0;
         r_pend_top  <= '0;
         r_pend_psc  <= '0;
         r_pend_ctr  <= 1'b0;
         r_act_duty  <= '0;
         r_act_top   <= '0;
         r_act_psc   <= '0;
         r_act_ctr   <= 1'b0;
         r_ack       <= 1'b0;
      end else begin
         if (i_load) begin
            r_pend      <= 1'b1;
            r_pend_duty <= i_duty;
            r_pend_top  <= i_period;
            r_pend_psc  <= i_prescale;
            r_pend_ctr  <= i_center;
         end else if (w_commit) begin
            r_pend <= 1'b0;
         end
         if (w_commit) begin
            r_act_duty <= r_pend_duty;
            r_act_top  <= r_pend_top;
            r_act_psc  <= r_pend_psc;
            r_act_ctr  <= r_pend_ctr;
         end
         r_ack <= w_commit;
      end
   end

   // Timebase, prescaler and registered outputs
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_psc  <= '0;
         r_cnt  <= '0;
         r_dn   <= 1'b0;
         r_en_q <= 1'b0;
         r_e    <= 1'b0;
         r_pwm  <= '0;
      end else begin
         r_en_q <= i_en;
         r_e    <= w_start;
         r_pwm  <= w_pwm;
         if (!i_en || w_rise || w_tick) begin
            r_psc <= '0;
         end else begin
            r_psc <= r_psc + PRESCALE_W'(1);
         end
         if (!i_en) begin
            r_cnt <= '0;
            r_dn  <= 1'b0;
         end else begin
            r_cnt <= w_cnt_nxt;
            r_dn  <= w_dn_nxt;
         end
      end
   end

   assign o_load_ack = r_ack;
   assign o_pwm_out  = r_pwm;
   assign o_e        = r_e;
   assign o_cnt      = r_cnt;

endmodule

// File: tb/tb_pwm_gen_multi.sv
// Scoreboard bench for pwm_gen_multi: per-period length, max count
// and per-channel high time checked against a closed-form model.
module tb_pwm_gen_multi;

   localparam int W = 8;
   localparam int N = 4;
   localparam int P = 8;

   logic           clk    = 1'b0;
   logic           rst_n  = 1'b0;
   logic           en     = 1'b0;
   logic           center = 1'b0;
   logic           load   = 1'b0;
   logic [W-1:0]   period = '0;
   logic [P-1:0]   psc    = '0;
   logic [N*W-1:0] duty   = '0;
   logic           ack;
   logic           e;
   logic [N-1:0]   pwm;
   logic [W-1:0]   cnt;

   int n_chk = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   pwm_gen_multi #(.WIDTH(W), .NUM_CH(N), .PRESCALE_W(P)) dut (
      .i_clk      (clk),
      .i_rst_n    (rst_n),
      .i_en       (en),
      .i_center   (center),
      .i_period   (period),
      .i_prescale (psc),
      .i_duty     (duty),
      .i_load     (load),
      .o_load_ack (ack),
      .o_pwm_out  (pwm),
      .o_e        (e),
      .o_cnt      (cnt)
   );

   typedef struct packed {
      logic [15:0]         per;
      logic [15:0]         maxc;
      logic [N-1:0][15:0]  hi;
   } exp_t;

   exp_t q[$];
   exp_t cur;
   bit   mon_on = 1'b0;
   bit   have   = 1'b0;
   int   len    = 0;
   int   maxc   = 0;
   int   pcount = 0;
   int   hi[N];

   task automatic chk(input string nm, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   // Period and high time follow directly from the mode rules
   function automatic exp_t model(input int top, input int pv,
                                  input bit ctr, input logic [N*W-1:0] d);
      exp_t x;
      int k;
      int dv;
      int h;
      k = pv + 1;
      x.maxc = 16'(top);
      x.per  = ctr ? 16'(k * 2 * top) : 16'(k * (top + 1));
      for (int i = 0; i < N; i++) begin
         dv = int'(d[i*W +: W]);
         if (!ctr) h = (dv < top + 1) ? dv : top + 1;
         else if (dv == 0) h = 0;
         else if (dv <= top) h = 2 * dv - 1;
         else h = 2 * top;
         x.hi[i] = 16'(k * h);
      end
      return x;
   endfunction

   // Monitor: measure each complete period, compare, switch config on ack
   always @(negedge clk) begin
      if (mon_on) begin
         if (e) begin
            if (have) begin
               for (int i = 0; i < N; i++) if (pwm[i]) hi[i]++;
               chk("period_len", len + 1, int'(cur.per));
               chk("max_cnt", maxc, int'(cur.maxc));
               for (int i = 0; i < N; i++)
                  chk($sformatf("high_ch%0d", i), hi[i], int'(cur.hi[i]));
               pcount++;
            end
            chk("cnt_at_e", int'(cnt), 0);
            if (ack) begin
               chk("ack_has_pending", int'(q.size() > 0), 1);
               if (q.size() > 0) begin
                  cur    = q.pop_front();
                  pcount = 0;
               end
            end
            have = 1'b1;
            len  = 0;
            maxc = 0;
            for (int i = 0; i < N; i++) hi[i] = 0;
         end else if (have) begin
            len++;
            if (int'(cnt) > maxc) maxc = int'(cnt);
            for (int i = 0; i < N; i++) if (pwm[i]) hi[i]++;
            chk("ack_only_with_e", int'(ack), 0);
         end
      end
   end

   task automatic wait_e();
      int t;
      t = 0;
      do begin
         @(negedge clk);
         t++;
      end while (!e && t < 500);
      chk("e_timeout", int'(e), 1);
   endtask

   task automatic settle();
      int t;
      t = 0;
      while (!(q.size() == 0 && pcount >= 2) && t < 3000) begin
         @(negedge clk);
         t++;
      end
      chk("settle_timeout", int'(t < 3000), 1);
   endtask

   task automatic rand_cfg();
      int top;
      center = 1'($urandom_range(0, 1));
      top    = center ? int'($urandom_range(1, 12)) : int'($urandom_range(0, 12));
      period = W'(top);
      psc    = P'($urandom_range(0, 3));
      for (int i = 0; i < N; i++)
         duty[i*W +: W] = ($urandom_range(0, 4) == 0) ? 8'd255
                        : W'($urandom_range(0, top + 2));
   endtask

   initial begin
      bit two;
      int t;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("rst_cnt", int'(cnt), 0);
      chk("rst_pwm", int'(pwm), 0);
      chk("rst_e", int'(e), 0);
      chk("rst_ack", int'(ack), 0);

      center = 1'b0;
      period = 8'd9;
      psc    = 8'd0;
      duty   = {8'd255, 8'd10, 8'd3, 8'd0};
      load   = 1'b1;
      @(negedge clk);
      load = 1'b0;
      chk("ack_capture", int'(ack), 0);
      @(negedge clk);
      chk("ack_en0", int'(ack), 1);
      chk("e_en0", int'(e), 0);
      @(negedge clk);
      chk("ack_pulse", int'(ack), 0);

      cur    = model(9, 0, 1'b0, duty);
      mon_on = 1'b1;
      en     = 1'b1;
      @(negedge clk);
      chk("e_on_rise", int'(e), 1);

      for (int n = 0; n < 22; n++) begin
         settle();
         wait_e();
         two = (cur.per >= 4) && (n == 2 || $urandom_range(0, 1) == 1);
         if (two) begin
            rand_cfg();
            load = 1'b1;
            @(negedge clk);
         end
         if (n == 0) begin
            center = 1'b1; period = 8'd4; psc = 8'd0;
            duty = {8'd0, 8'd5, 8'd4, 8'd2};
         end else if (n == 1) begin
            center = 1'b0; period = 8'd3; psc = 8'd2;
            duty = {4{8'd2}};
         end else begin
            rand_cfg();
         end
         load = 1'b1;
         q.push_back(model(int'(period), int'(psc), center, duty));
         @(negedge clk);
         load = 1'b0;
      end
      settle();

      wait_e();
      repeat (2) @(negedge clk);
      mon_on = 1'b0;
      en     = 1'b0;
      @(negedge clk);
      chk("en0_pwm", int'(pwm), 0);
      chk("en0_cnt", int'(cnt), 0);
      chk("en0_e", int'(e), 0);

      center = 1'b0; period = 8'd9; psc = 8'd0; duty = {4{8'd255}};
      load = 1'b1;
      @(negedge clk);
      load = 1'b0;
      @(negedge clk);
      chk("ack_en0_b", int'(ack), 1);
      en = 1'b1;
      @(negedge clk);
      chk("e_on_rise_b", int'(e), 1);

      t = 0;
      while (cnt != 8'd5 && t < 100) begin
         @(negedge clk);
         t++;
      end
      chk("cnt_reach5", int'(cnt), 5);
      chk("pwm_full", int'(pwm), 15);
      #2 rst_n = 1'b0;
      #1;
      chk("async_rst_pwm", int'(pwm), 0);
      chk("async_rst_cnt", int'(cnt), 0);
      chk("async_rst_e", int'(e), 0);
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("top0_e", int'(e), 1);
         chk("top0_cnt", int'(cnt), 0);
         chk("top0_pwm", int'(pwm), 0);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
